// File: rtl/sp_ram_arbiter_pkg.sv
// Shared memory-subsystem definitions: requester indices, arbiter FSM states
// and the two-way round-robin pick used by shared SRAM ports.
package sp_ram_arbiter_pkg;

  localparam int unsigned MEM_NUM_REQ  = 2;
  localparam int unsigned MEM_REQ_IF   = 0;
  localparam int unsigned MEM_REQ_DATA = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_arb_state_e;

  // On a tie, the requester that did not win last time gets the grant.
  function automatic logic [1:0] rr2_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-granted pointer; grant is
// combinational from the requests and gated by en_i.
module rr_arb2
  import sp_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      gnt_o = rr2_pick(req_i, last_q);
    end
  end

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= 1'b1;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Arbiter/sequencer for the single SRAM port: optional zero sweep after reset,
// then round-robin sharing between instruction fetch and data requesters.
module sp_ram_arbiter
  import sp_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 512,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                                clk,
  input  logic                                rstn_i,
  input  logic [MEM_NUM_REQ-1:0]              req_i,
  output logic [MEM_NUM_REQ-1:0]              gnt_o,
  input  logic [MEM_NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [MEM_NUM_REQ-1:0]              we_i,
  input  logic [MEM_NUM_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [MEM_NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [MEM_NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                init_busy_o,
  output logic                                ram_en_o,
  output logic                                ram_we_o,
  output logic [DATA_WIDTH/8-1:0]             ram_be_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_o,
  output logic [DATA_WIDTH-1:0]               ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]               ram_rdata_i
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam sram_arb_state_e RESET_STATE = INIT_ZERO ? INIT : RUN;

  sram_arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [MEM_NUM_REQ-1:0] gnt;
  logic [MEM_NUM_REQ-1:0] rvalid_q;
  logic                   sweep;
  logic                   arb_en;
  logic                   sel;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_we;
  logic [BE_W-1:0]        sel_be;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  // Gating with rstn_i keeps the RAM strobes and grants at 0 while reset is held.
  assign sweep  = (state_q == INIT) && rstn_i;
  assign arb_en = (state_q == RUN) && rstn_i;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rstn_i (rstn_i),
    .en_i   (arb_en),
    .req_i  (req_i),
    .gnt_o  (gnt)
  );

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= gnt;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && cnt_q == LAST_WORD) begin
      state_d = RUN;
    end
  end

  always_comb begin
    sel = gnt[MEM_REQ_DATA];
    if (sel) begin
      sel_addr  = addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
      sel_we    = we_i[1];
      sel_be    = be_i[2*BE_W-1:BE_W];
      sel_wdata = wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      sel_addr  = addr_i[ADDR_WIDTH-1:0];
      sel_we    = we_i[0];
      sel_be    = be_i[BE_W-1:0];
      sel_wdata = wdata_i[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (sweep) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_be_o    = '1;
      ram_addr_o  = ADDR_WIDTH'(cnt_q) << 2;
      ram_wdata_o = '0;
    end else if (|gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = sel_we;
      ram_be_o    = sel_be;
      ram_addr_o  = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
      ram_wdata_o = sel_wdata;
    end
  end

  assign gnt_o       = gnt;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = ram_rdata_i;
  assign init_busy_o = (state_q == INIT);

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port RAM behind it,
// plus a second instance built without the zero sweep.
module tb_sp_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [21:0] addr;
  logic [1:0]  we;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        init_busy;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [1:0]  req2;
  logic [1:0]  gnt2;
  logic [1:0]  rvalid2;
  logic [31:0] rdata2;
  logic        init_busy2;
  logic        ram_en2;
  logic        ram_we2;
  logic [3:0]  ram_be2;
  logic [10:0] ram_addr2;
  logic [31:0] ram_wdata2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [512];

  always #5 clk = ~clk;

  sp_ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .NUM_WORDS(512), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rstn_i(rstn), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .init_busy_o(init_busy), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  sp_ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .NUM_WORDS(512), .INIT_ZERO(1'b0)) dut2 (
    .clk(clk), .rstn_i(rstn), .req_i(req2), .gnt_o(gnt2), .addr_i(22'h0), .we_i(2'b00),
    .be_i(8'hFF), .wdata_i(64'h0), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .init_busy_o(init_busy2), .ram_en_o(ram_en2), .ram_we_o(ram_we2), .ram_be_o(ram_be2),
    .ram_addr_o(ram_addr2), .ram_wdata_o(ram_wdata2), .ram_rdata_i(32'h0)
  );

  // Behavioural SRAM: byte-masked write, registered read data.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr[10:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rdata <= mem[ram_addr[10:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sweep(input int i);
    chk($sformatf("sweep_gnt[%0d]", i), 32'(gnt), 32'h0);
    chk($sformatf("sweep_busy[%0d]", i), 32'(init_busy), 32'h1);
    chk($sformatf("sweep_en[%0d]", i), 32'(ram_en), 32'h1);
    chk($sformatf("sweep_we[%0d]", i), 32'(ram_we), 32'h1);
    chk($sformatf("sweep_be[%0d]", i), 32'(ram_be), 32'hF);
    chk($sformatf("sweep_addr[%0d]", i), 32'(ram_addr), 32'(i * 4));
    chk($sformatf("sweep_wdata[%0d]", i), ram_wdata, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_busy"}, 32'(init_busy), 32'h1);
    chk({tag, "_en"}, 32'(ram_en), 32'h0);
    chk({tag, "_we"}, 32'(ram_we), 32'h0);
    chk({tag, "_be"}, 32'(ram_be), 32'h0);
  endtask

  initial begin
    rstn  = 1'b0;
    req   = 2'b00;
    addr  = '0;
    we    = 2'b00;
    be    = 8'hFF;
    wdata = '0;
    req2  = 2'b01;
    repeat (3) step();

    chk_reset_outputs("reset");
    chk("reset_busy2", 32'(init_busy2), 32'h0);
    chk("reset_gnt2", 32'(gnt2), 32'h0);

    // Release; the sweep-less instance grants in the very first cycle.
    rstn = 1'b1;
    req2 = 2'b10;
    req  = 2'b11;
    addr = {11'h7FC, 11'h100};
    #1;
    chk("first_gnt2", 32'(gnt2), 32'h2);
    chk("first_en2", 32'(ram_en2), 32'h1);
    for (int i = 0; i < 512; i++) begin
      chk_sweep(i);
      step();
      req2 = 2'b00;
    end
    chk("rvalid2_after_first", 32'(rvalid2), 32'h0);

    // Contention right as INIT ends: 0,1,0,1 then rvalid mirrors a cycle later.
    chk("busy_after_sweep", 32'(init_busy), 32'h0);
    chk("cont_gnt_a", 32'(gnt), 32'h1);
    chk("cont_addr_a", 32'(ram_addr), 32'h100);
    chk("cont_we_a", 32'(ram_we), 32'h0);
    step();
    chk("cont_rvalid_b", 32'(rvalid), 32'h1);
    chk("cont_rdata_b", rdata, 32'h0);
    chk("cont_gnt_b", 32'(gnt), 32'h2);
    chk("cont_addr_b", 32'(ram_addr), 32'h7FC);
    step();
    chk("cont_rvalid_c", 32'(rvalid), 32'h2);
    chk("cont_rdata_c", rdata, 32'h0);
    chk("cont_gnt_c", 32'(gnt), 32'h1);
    step();
    chk("cont_rvalid_d", 32'(rvalid), 32'h1);
    chk("cont_gnt_d", 32'(gnt), 32'h2);
    step();
    req = 2'b00;
    #1;
    chk("idle_rvalid_e", 32'(rvalid), 32'h2);
    chk("idle_gnt_e", 32'(gnt), 32'h0);
    chk("idle_en_e", 32'(ram_en), 32'h0);
    chk("idle_we_e", 32'(ram_we), 32'h0);
    step();
    chk("idle_rvalid_f", 32'(rvalid), 32'h0);

    // Requester 1 writes then reads back 0x040 back-to-back.
    req   = 2'b10;
    addr  = {11'h040, 11'h000};
    we    = 2'b10;
    be    = 8'hF0;
    wdata = {32'hDEADBEEF, 32'h0};
    #1;
    chk("wr1_gnt", 32'(gnt), 32'h2);
    chk("wr1_we", 32'(ram_we), 32'h1);
    chk("wr1_addr", 32'(ram_addr), 32'h040);
    chk("wr1_be", 32'(ram_be), 32'hF);
    chk("wr1_wdata", ram_wdata, 32'hDEADBEEF);
    step();
    chk("wr1_rvalid", 32'(rvalid), 32'h2);
    we = 2'b00;
    #1;
    chk("rd1_gnt", 32'(gnt), 32'h2);
    chk("rd1_we", 32'(ram_we), 32'h0);
    step();
    chk("rd1_rvalid", 32'(rvalid), 32'h2);
    chk("rd1_rdata", rdata, 32'hDEADBEEF);
    req = 2'b00;

    // Requester 0: unaligned partial write to 0x083, then full-word read.
    req   = 2'b01;
    addr  = {11'h000, 11'h083};
    we    = 2'b01;
    be    = 8'h03;
    wdata = {32'h0, 32'h1234ABCD};
    #1;
    chk("pw_gnt", 32'(gnt), 32'h1);
    chk("pw_addr", 32'(ram_addr), 32'h080);
    chk("pw_be", 32'(ram_be), 32'h3);
    step();
    chk("pw_rvalid", 32'(rvalid), 32'h1);
    we = 2'b00;
    be = 8'h0F;
    #1;
    chk("pr_gnt", 32'(gnt), 32'h1);
    step();
    chk("pr_rvalid", 32'(rvalid), 32'h1);
    chk("pr_rdata", rdata, 32'h0000ABCD);

    // Last winner was requester 0, so a tie now goes to requester 1.
    req = 2'b11;
    #1;
    chk("tie_after_r0", 32'(gnt), 32'h2);

    // Reset while a grant is pending: no rvalid may emerge.
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midtxn");
    req = 2'b00;
    step();
    chk("midtxn_rvalid_after_edge", 32'(rvalid), 32'h0);
    step();

    rstn = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      chk_sweep(i);
      step();
    end
    chk_sweep(200);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midsweep");
    step();

    rstn = 1'b1;
    #1;
    for (int i = 0; i < 512; i++) begin
      chk_sweep(i);
      step();
    end
    chk("busy_after_resweep", 32'(init_busy), 32'h0);
    chk("en_after_resweep", 32'(ram_en), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-port arbiter and sequencer in front of the single read/write port of the 2 KB SRAM wrapper (`sp_ram_wrap`, 512 x 32-bit words). It shares that port between two requesters, instruction fetch (index 0) and data (index 1), using a req/gnt/rvalid handshake with round-robin tie-breaking. After reset it optionally sweeps the whole array to zero before granting any request. It sits between the core-side bus ports and the RAM wrapper inside the memory subsystem.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: byte-address width; word index is `addr[ADDR_WIDTH-1:2]`.
- `DATA_WIDTH`, 32: data width; byte enables are `DATA_WIDTH/8` bits wide.
- `NUM_WORDS`, 512: number of words swept by the init sequence.
- `INIT_ZERO`, 1: 1 enables the zero sweep after reset; 0 skips it.

Ports (requester buses are packed, with requester r in slice r):
- `clk` in, 1: single clock, rising edge.
- `rstn_i` in, 1: asynchronous, active-low reset.
- `req_i` in, 2: request per requester.
- `gnt_o` out, 2: grant per requester; reset 0.
- `addr_i` in, 2*ADDR_WIDTH: byte address per requester.
- `we_i` in, 2: 1 = write, 0 = read.
- `be_i` in, 2*DATA_WIDTH/8: byte enables.
- `wdata_i` in, 2*DATA_WIDTH: write data.
- `rvalid_o` out, 2: response valid, one cycle after grant; reset 0.
- `rdata_o` out, DATA_WIDTH: shared read data, meaningful only with `rvalid_o`.
- `init_busy_o` out, 1: zero sweep in progress; reset value equals `INIT_ZERO`.
- `ram_en_o` out, 1: access issued this cycle; reset 0.
- `ram_we_o` out, 1: write strobe, active high (wrapper inverts it); reset 0.
- `ram_be_o` out, DATA_WIDTH/8: byte mask to the RAM; reset 0.
- `ram_addr_o` out, ADDR_WIDTH: byte address with `[1:0]`=0.
- `ram_wdata_o` out, DATA_WIDTH: write data.
- `ram_rdata_i` in, DATA_WIDTH: RAM read data, valid the cycle after the access.

## Operation
- FSM states: INIT, RUN. Reset enters INIT if `INIT_ZERO`=1, otherwise RUN.
- INIT:
  - Word counter runs 0..NUM_WORDS-1, one write per cycle: `ram_en_o`=1, `ram_we_o`=1, `ram_be_o`=all ones, `ram_wdata_o`=0, `ram_addr_o`=counter<<2.
  - `gnt_o`=0 and `init_busy_o`=1 throughout.
  - After the write to word NUM_WORDS-1, the FSM moves to RUN and `init_busy_o` falls.
- RUN grant rules:
  - `gnt_o` is combinational from `req_i`. At most one grant per cycle.
  - Single requester: that requester is granted.
  - Both requesting: grant goes to the requester not granted most recently.
  - The last-granted pointer resets to 1, so requester 0 wins the first tie. The pointer updates only on a grant.
- The RAM port is a combinational mux of the granted requester's addr/we/be/wdata. `ram_en_o`=|`gnt_o`. With no grant, `ram_en_o`=0 and `ram_we_o`=0.
- `ram_addr_o` forces bits `[1:0]` to 0. Unaligned addresses are not faulted.
- Response: a registered one-hot copy of `gnt_o` drives `rvalid_o`, for both reads and writes. `rdata_o`=`ram_rdata_i`, unregistered. Write responses carry don't-care data.
- Handshake: a requester holds req/addr/we/be/wdata stable until granted. It may issue back-to-back requests, and its new request may be granted in the same cycle as the previous rvalid.
- Reset mid-INIT restarts the sweep from word 0. Reset mid-transaction drops any pending rvalid.

## Timing
- Request to grant: 0 cycles when uncontended. Worst case 1 extra cycle under continuous contention (round-robin bound).
- Grant to rvalid/rdata: exactly 1 cycle.
- Throughput: one access per cycle total. Each requester gets at least every other cycle under contention.
- INIT duration: NUM_WORDS cycles after reset release (512 by default). The first grant is possible in cycle NUM_WORDS.
- Registered state: FSM, init counter, last-granted pointer, rvalid.

## Structure
- Shared memory package:
  - `MEM_NUM_REQ`=2, `MEM_REQ_IF`=0, `MEM_REQ_DATA`=1.
  - Enum `sram_arb_state_e` {INIT, RUN}.
- One sub-module: `rr_arb2`, a two-way round-robin grant with the last-granted pointer. It is reusable for other shared macros.
- This block connects to `sp_ram_wrap` in the parent; this block does not instantiate the wrapper.

## Test plan
- Reset release, `INIT_ZERO`=1: `init_busy_o` is high for exactly 512 cycles, addresses 0x000..0x7FC are written with 0 and be=0xF, no grants occur. Afterwards, a read of 0x100 returns 0.
- Requester 1 writes 0xDEADBEEF to 0x040 with be=0xF, then reads 0x040: each grant is in the same cycle as req, rvalid follows 1 cycle later, and `rdata_o`=0xDEADBEEF.
- Both requesters hold req for 4 cycles after INIT: grants alternate 0,1,0,1 and rvalid mirrors them one cycle later.
- Partial write: be=0x3 with 0x1234ABCD to a word holding 0x0: the readback is 0x0000ABCD.
- Assert `rstn_i` at sweep word 200: all outputs return to reset values, and after release the sweep restarts at 0x000 and runs for 512 cycles.
- With `INIT_ZERO`=0: `init_busy_o`=0 out of reset, and a request in the first cycle after release is granted in that cycle.
